// File: rtl/block_scheduler_pkg.sv
// ============================================================================
// Module      : block_scheduler_pkg
// Description : Shared widths, empty-shape code, FSM encodings and LFSR step
//               for the obstacle lane scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package block_scheduler_pkg;

    localparam int SHAPE_ENCODE_LENGTH = 3;
    localparam int COORDINATE_LENGTH   = 10;
    localparam int NUM_SLOTS           = 4;
    localparam int SHAPE_NONE          = 0;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_CLEAR  = 2'd1;
    localparam state_t ST_RUN    = 2'd2;
    localparam state_t ST_FROZEN = 2'd3;

    localparam logic [7:0] LFSR_SEED = 8'hA5;

    // Fibonacci form, taps 8,6,5,4 (bits 7,5,4,3), shifting towards the MSB.
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/block_scheduler_slot.sv
// ============================================================================
// Module      : block_scheduler_slot
// Description : One obstacle lane: holds shape and x, scrolls left, retires
//               at the left edge, and accepts a spawn load when empty.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module block_scheduler_slot
    import block_scheduler_pkg::*;
#(
    parameter int SHAPE_W = SHAPE_ENCODE_LENGTH,
    parameter int COORD_W = COORDINATE_LENGTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_clear,
    input  logic               i_move,
    input  logic               i_load,
    input  logic [SHAPE_W-1:0] i_load_shape,
    input  logic [COORD_W-1:0] i_load_x,
    input  logic [2:0]         i_speed,
    output logic [SHAPE_W-1:0] o_shape,
    output logic [COORD_W-1:0] o_x,
    output logic               o_free
);

    localparam logic [SHAPE_W-1:0] c_shape_none = SHAPE_W'(SHAPE_NONE);

    logic [SHAPE_W-1:0] shape_q, shape_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] w_step;

    assign w_step = {{(COORD_W-3){1'b0}}, i_speed};

    always_comb begin
        shape_d = shape_q;
        x_d     = x_q;
        if (i_clear) begin
            shape_d = c_shape_none;
            x_d     = '0;
        end else if (i_load) begin
            shape_d = i_load_shape;
            x_d     = i_load_x;
        end else if (i_move && (shape_q != c_shape_none)) begin
            // Retiring at x <= step is what keeps x from wrapping below zero.
            if (x_q <= w_step) begin
                shape_d = c_shape_none;
                x_d     = '0;
            end else begin
                x_d     = x_q - w_step;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shape_q <= c_shape_none;
            x_q     <= '0;
        end else begin
            shape_q <= shape_d;
            x_q     <= x_d;
        end
    end

    assign o_shape = shape_q;
    assign o_x     = x_q;
    assign o_free  = (shape_q == c_shape_none);

endmodule

`default_nettype wire

// File: rtl/block_scheduler.sv
// ============================================================================
// Module      : block_scheduler
// Description : Spawns, scrolls and retires four obstacle lanes for the
//               referee. Define BLOCK_SCHEDULER_RAMP_EN for the speed ramp.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module block_scheduler
    import block_scheduler_pkg::*;
#(
    parameter int SHAPE_W    = SHAPE_ENCODE_LENGTH,
    parameter int COORD_W    = COORDINATE_LENGTH,
    parameter int SCREEN_W   = 640,
    parameter int SPAWN_GAP  = 150,
    parameter int STEP_INIT  = 2,
    parameter int STEP_MAX   = 6,
    parameter int RAMP_TICKS = 1000
) (
    input  logic                         CLK,
    input  logic                         RESET_N,
    input  logic                         START,
    input  logic                         OVER,
    output logic [NUM_SLOTS*SHAPE_W-1:0] BLOCK_SHAPE,
    output logic [NUM_SLOTS*COORD_W-1:0] BLOCK_START_X,
    output logic                         GAME_READY,
    output logic [2:0]                   SPEED
);

    localparam int                 c_cnt_w    = (SPAWN_GAP > 2) ? $clog2(SPAWN_GAP) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(SPAWN_GAP - 1);
    localparam logic [COORD_W-1:0] c_spawn_x  = COORD_W'(SCREEN_W);

    if ((SPAWN_GAP < 2) || (SCREEN_W >= (1 << COORD_W)) || (STEP_INIT < 1) ||
        (STEP_MAX < STEP_INIT) || (STEP_MAX > 7) || (RAMP_TICKS < 2) ||
        (SHAPE_W > 8)) begin : g_cfg_error
        $error("block_scheduler: illegal parameter combination");
    end

    state_t               state_q, state_d;
    logic                 game_ready_q, game_ready_d;
    logic [c_cnt_w-1:0]   spawn_cnt_q, spawn_cnt_d;
    logic [7:0]           lfsr_q, lfsr_d;

    logic                 w_clear;
    logic                 w_run_active;
    logic                 w_spawn_due;
    logic                 w_found;
    logic [NUM_SLOTS-1:0] w_free;
    logic [NUM_SLOTS-1:0] w_load;
    logic [SHAPE_W-1:0]   w_spawn_shape;

    // ---------------- FSM: state register / next state / outputs ----------
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (START) state_d = ST_CLEAR;
            ST_CLEAR:  state_d = ST_RUN;
            ST_RUN:    if (OVER) state_d = ST_FROZEN;
            ST_FROZEN: state_d = ST_FROZEN;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        game_ready_d = (state_d == ST_RUN);
    end

    // ---------------- Datapath control ------------------------------------
    // OVER gates everything in its own cycle, so the field freezes as sampled.
    assign w_clear      = (state_q == ST_CLEAR);
    assign w_run_active = (state_q == ST_RUN) && !OVER;
    assign w_spawn_due  = w_run_active && (spawn_cnt_q == c_cnt_last);

    always_comb begin
        spawn_cnt_d = spawn_cnt_q;
        if (w_clear) begin
            spawn_cnt_d = '0;
        end else if (w_run_active) begin
            if (spawn_cnt_q == c_cnt_last) begin
                if (|w_free) spawn_cnt_d = '0;
            end else begin
                spawn_cnt_d = spawn_cnt_q + c_cnt_w'(1);
            end
        end
    end

    always_comb begin
        w_load  = '0;
        w_found = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (w_spawn_due && w_free[i] && !w_found) begin
                w_load[i] = 1'b1;
                w_found   = 1'b1;
            end
        end
    end

    always_comb begin
        lfsr_d        = lfsr_next(lfsr_q);
        w_spawn_shape = lfsr_q[SHAPE_W-1:0];
        if (w_spawn_shape == SHAPE_W'(SHAPE_NONE)) w_spawn_shape = SHAPE_W'(1);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            game_ready_q <= 1'b0;
            spawn_cnt_q  <= '0;
            lfsr_q       <= LFSR_SEED;
        end else begin
            game_ready_q <= game_ready_d;
            spawn_cnt_q  <= spawn_cnt_d;
            lfsr_q       <= lfsr_d;
        end
    end

    assign GAME_READY = game_ready_q;

`ifdef BLOCK_SCHEDULER_RAMP_EN
    localparam int                  c_ramp_w    = (RAMP_TICKS > 2) ? $clog2(RAMP_TICKS) : 1;
    localparam logic [c_ramp_w-1:0] c_ramp_last = c_ramp_w'(RAMP_TICKS - 1);

    logic [c_ramp_w-1:0] ramp_cnt_q, ramp_cnt_d;
    logic [2:0]          speed_q, speed_d;

    always_comb begin
        ramp_cnt_d = ramp_cnt_q;
        speed_d    = speed_q;
        if (w_clear) begin
            ramp_cnt_d = '0;
            speed_d    = 3'(STEP_INIT);
        end else if (w_run_active) begin
            if (ramp_cnt_q == c_ramp_last) begin
                ramp_cnt_d = '0;
                if (speed_q < 3'(STEP_MAX)) speed_d = speed_q + 3'd1;
            end else begin
                ramp_cnt_d = ramp_cnt_q + c_ramp_w'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ramp_cnt_q <= '0;
            speed_q    <= 3'(STEP_INIT);
        end else begin
            ramp_cnt_q <= ramp_cnt_d;
            speed_q    <= speed_d;
        end
    end

    assign SPEED = speed_q;
`else
    assign SPEED = 3'(STEP_INIT);
`endif

    // ---------------- Lanes -------------------------------------------------
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
        block_scheduler_slot #(
            .SHAPE_W (SHAPE_W),
            .COORD_W (COORD_W)
        ) u_slot (
            .clk          (CLK),
            .rst_n        (RESET_N),
            .i_clear      (w_clear),
            .i_move       (w_run_active),
            .i_load       (w_load[gi]),
            .i_load_shape (w_spawn_shape),
            .i_load_x     (c_spawn_x),
            .i_speed      (SPEED),
            .o_shape      (BLOCK_SHAPE[gi*SHAPE_W +: SHAPE_W]),
            .o_x          (BLOCK_START_X[gi*COORD_W +: COORD_W]),
            .o_free       (w_free[gi])
        );
    end

endmodule

`default_nettype wire
